// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
//
// Sits between the MEM stage and a 2-way data cache plus an SRAM controller.
// Loads go to the cache first. On a miss, a 64-bit line is fetched from SRAM,
// written into the cache, and the requested word is returned.
// Stores go straight through to SRAM (write-through, no-write-allocate), and
// the matching cache line is invalidated.
// The pipeline is stalled by holding `ready` low.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   address, wdata      : CPU byte address / store data (held until ready)
//   MEM_R_EN, MEM_W_EN  : CPU load / store request (store has priority)
//   rdata, ready        : load data and request-complete handshake
//   cache_*             : cache address, fill data, hit/fill/invalidate strobes,
//                         hit flag and read word from the cache
//   sram_*              : SRAM address, write data, read/write requests,
//                         line data and one-cycle completion pulse
//   hit_count, miss_count : wrapping load hit / miss performance counters
// -----------------------------------------------------------------------------
module cache_controller #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      address,
    input  logic [31:0]      wdata,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    output logic [31:0]      rdata,
    output logic             ready,
    output logic [18:0]      cache_addr,
    output logic [63:0]      cache_wdata,
    output logic             cache_r_en,
    output logic             cache_w_en,
    output logic             cache_invalidate,
    input  logic             cache_hit,
    input  logic [31:0]      cache_rdata,
    output logic [31:0]      sram_address,
    output logic [31:0]      sram_wdata,
    output logic             sram_r_en,
    output logic             sram_w_en,
    input  logic [63:0]      sram_rdata,
    input  logic             sram_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_READ_MISS = 2'd1;
    localparam logic [1:0] ST_WRITE     = 2'd2;

    logic [1:0]       state_q,      state_d;
    logic [CNT_W-1:0] hit_count_q,  hit_count_d;
    logic [CNT_W-1:0] miss_count_q, miss_count_d;
    logic [31:0]      offset_s;

    // Address translation into cache/SRAM space (wraps modulo 2^32)
    always_comb begin
        offset_s = address - ADDR_BASE;
    end

    assign cache_addr   = offset_s[18:0];
    assign sram_address = offset_s;
    assign sram_wdata   = wdata;
    assign cache_wdata  = sram_rdata;
    assign hit_count    = hit_count_q;
    assign miss_count   = miss_count_q;

    // Next-state, counter update and combinational handshake/strobe decode
    always_comb begin
        state_d          = state_q;
        hit_count_d      = hit_count_q;
        miss_count_d     = miss_count_q;
        rdata            = 32'd0;
        ready            = 1'b0;
        cache_r_en       = 1'b0;
        cache_w_en       = 1'b0;
        cache_invalidate = 1'b0;
        sram_r_en        = 1'b0;
        sram_w_en        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MEM_W_EN) begin
                    // Store wins over a simultaneous load; the load is dropped.
                    // Invalidate unconditionally, whether or not the line is present.
                    cache_invalidate = 1'b1;
                    state_d          = ST_WRITE;
                end else if (MEM_R_EN) begin
                    if (cache_hit) begin
                        cache_r_en  = 1'b1;
                        rdata       = cache_rdata;
                        ready       = 1'b1;
                        hit_count_d = hit_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        miss_count_d = miss_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_d      = ST_READ_MISS;
                    end
                end else begin
                    // A stray sram_ready here is deliberately ignored.
                    ready = 1'b1;
                end
            end

            ST_READ_MISS: begin
                sram_r_en = 1'b1;
                if (sram_ready) begin
                    cache_w_en = 1'b1;
                    // Word 0 of a line sits in the upper half, matching the cache
                    rdata      = offset_s[2] ? sram_rdata[31:0] : sram_rdata[63:32];
                    ready      = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d = ST_READ_MISS;
                end
            end

            ST_WRITE: begin
                sram_w_en = 1'b1;
                if (sram_ready) begin
                    ready   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WRITE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset aborts any outstanding request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hit_count_q  <= {CNT_W{1'b0}};
            miss_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule
